// File: rtl/cla_sub32_pipe.sv
// Four-stage pipelined 32-bit subtractor, D = A - B - Bin.
// Each stage resolves one byte with an 8-bit carry-lookahead slice; the whole pipe advances in lock-step.
module cla_sub32_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] D,
    output logic        Bout,
    output logic        overFlow,
    output logic        zero
);

    // Returns {carry_out, sum[7:0]} of a + ~b + cin, with every carry in lookahead form.
    function automatic logic [8:0] cla8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [7:0] g;
        logic [7:0] p;
        logic [8:0] c;
        logic       t;
        g    = a & ~b;
        p    = a ^ ~b;
        c    = 9'b0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            t = cin;
            for (int j = 0; j <= i; j++) t = t & p[j];
            c[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int k = j + 1; k <= i; k++) t = t & p[k];
                c[i+1] = c[i+1] | t;
            end
        end
        return {c[8], p ^ c[7:0]};
    endfunction

    // Each stage keeps only the operand bytes still to be processed.
    logic        r_v1, r_v2, r_v3, r_v4;
    logic [23:0] r_a1, r_b1;
    logic [15:0] r_a2, r_b2;
    logic [7:0]  r_a3, r_b3;
    logic [7:0]  r_d1;
    logic [15:0] r_d2;
    logic [23:0] r_d3;
    logic [31:0] r_d4;
    logic        r_c1, r_c2, r_c3;
    logic        r_bout, r_ovf, r_zero;

    logic        w_adv;
    logic [8:0]  w_s0, w_s1, w_s2, w_s3;
    logic [31:0] w_d;
    logic        w_ovf;

    assign w_adv    = !r_v4 | out_ready;
    assign in_ready = w_adv;

    assign w_s0  = cla8(A[7:0], B[7:0], !Bin);
    assign w_s1  = cla8(r_a1[7:0], r_b1[7:0], r_c1);
    assign w_s2  = cla8(r_a2[7:0], r_b2[7:0], r_c2);
    assign w_s3  = cla8(r_a3, r_b3, r_c3);
    assign w_d   = {w_s3[7:0], r_d3};
    assign w_ovf = (r_a3[7] != r_b3[7]) && (w_s3[7] != r_a3[7]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_v4   <= 1'b0;
            r_a1   <= '0;
            r_b1   <= '0;
            r_a2   <= '0;
            r_b2   <= '0;
            r_a3   <= '0;
            r_b3   <= '0;
            r_d1   <= '0;
            r_d2   <= '0;
            r_d3   <= '0;
            r_d4   <= '0;
            r_c1   <= 1'b0;
            r_c2   <= 1'b0;
            r_c3   <= 1'b0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_adv) begin
            r_v1   <= in_valid;
            r_a1   <= A[31:8];
            r_b1   <= B[31:8];
            r_d1   <= w_s0[7:0];
            r_c1   <= w_s0[8];

            r_v2   <= r_v1;
            r_a2   <= r_a1[23:8];
            r_b2   <= r_b1[23:8];
            r_d2   <= {w_s1[7:0], r_d1};
            r_c2   <= w_s1[8];

            r_v3   <= r_v2;
            r_a3   <= r_a2[15:8];
            r_b3   <= r_b2[15:8];
            r_d3   <= {w_s2[7:0], r_d2};
            r_c3   <= w_s2[8];

            // Flags are registered so outputs come straight from stage-4 flops.
            r_v4   <= r_v3;
            r_d4   <= w_d;
            r_bout <= !w_s3[8];
            r_ovf  <= w_ovf;
            r_zero <= (w_d == 32'd0);
        end
    end

    assign out_valid = r_v4;
    assign D         = r_d4;
    assign Bout      = r_bout;
    assign overFlow  = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_cla_sub32_pipe.sv
// Self-checking bench for cla_sub32_pipe: directed cases, a randomized back-pressure stream and a mid-stream reset,
// all checked against an arithmetic model of A - B - Bin.
module tb_cla_sub32_pipe;

    typedef struct packed {
        logic [31:0] d;
        logic        bout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] D;
    logic        Bout;
    logic        overFlow;
    logic        zero;

    int n_pass  = 0;
    int n_total = 0;

    res_t exp_q[$];

    cla_sub32_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .overFlow  (overFlow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        res_t   r;
        longint ua, ub, sa, sb, du, ds;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        du = ua - ub - longint'(bin);
        ds = sa - sb - longint'(bin);
        r.d    = 32'(du);
        r.bout = (du < 0);
        r.ovf  = (ds > 64'sd2147483647) || (ds < -64'sd2147483648);
        r.zero = (r.d == 32'd0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_res(input string tag, input res_t exp);
        chk({tag, "_D"},        D,                exp.d);
        chk({tag, "_Bout"},     32'(Bout),        32'(exp.bout));
        chk({tag, "_overFlow"}, 32'(overFlow),    32'(exp.ovf));
        chk({tag, "_zero"},     32'(zero),        32'(exp.zero));
    endtask

    // Presents one op on an idle pipe with out_ready=1 and checks latency and result.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b, input logic bin);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A = a; B = b; Bin = bin;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            A = $urandom; B = $urandom; Bin = 1'b0;
            chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        chk({tag, "_valid_t3"}, 32'(out_valid), 32'd1);
        chk_res(tag, model(a, b, bin));
    endtask

    initial begin
        int          sent, got, cyc, stall_left;
        logic        held;
        res_t        saved, e;
        logic [31:0] na, nb;
        logic        nbin;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Bin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk_res("rst", '0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        run_one("basic",    32'd5,          32'd3,          1'b0);
        run_one("uborrow",  32'd0,          32'd1,          1'b0);
        run_one("ovf_neg",  32'h8000_0000,  32'h0000_0001,  1'b0);
        run_one("ovf_pos",  32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0);
        run_one("xbyte",    32'h0000_0100,  32'h0000_0001,  1'b0);
        run_one("bin_neg",  32'd10,         32'd10,         1'b1);
        run_one("bin_zero", 32'd10,         32'd9,          1'b1);
        run_one("xbyte_hi", 32'h0100_0000,  32'h0000_0000,  1'b1);

        // Randomized stream with back-to-back in_valid and bursty out_ready.
        sent = 0; got = 0; cyc = 0; stall_left = 0; held = 1'b0; saved = '0;
        na = $urandom; nb = $urandom; nbin = 1'($urandom_range(0, 1));
        while (got < 16 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 2) == 0) begin
                out_ready  = 1'b0;
                stall_left = $urandom_range(0, 4);
            end else begin
                out_ready = 1'b1;
            end
            if (sent < 16) begin
                in_valid = 1'b1; A = na; B = nb; Bin = nbin;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("stream_in_ready_rule", 32'(in_ready), 32'(!out_valid | out_ready));
            if (held) begin
                chk("stall_valid_stable", 32'(out_valid), 32'd1);
                chk_res("stall_stable", saved);
            end
            held = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    chk("stream_expected_pending", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk_res("stream", e);
                    end
                    got++;
                end else begin
                    held  = 1'b1;
                    saved = '{d: D, bout: Bout, ovf: overFlow, zero: zero};
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(na, nb, nbin));
                sent++;
                na = $urandom; nb = $urandom; nbin = 1'($urandom_range(0, 1));
            end
        end
        chk("stream_count", 32'(got), 32'd16);
        chk("stream_leftover", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("stream_drained", 32'(out_valid), 32'd0);

        // Fill all four stages, then reset between edges.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; A = $urandom; B = $urandom; Bin = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("prefill_valid", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk_res("midrst", '0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("postrst_no_stale", 32'(out_valid), 32'd0);
        end
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        run_one("postrst", 32'h1234_5678, 32'h0FED_CBA9, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cla_sub32_pipe.md
# cla_sub32_pipe

Four-stage pipelined 32-bit subtractor, D = A − B − Bin. It complements the combinational 32-bit carry-lookahead adder and sits on the ALU datapath wherever a registered subtract or compare is needed. Each stage resolves one byte with an 8-bit carry-lookahead slice and passes its carry to the next stage. Both ends use valid/ready handshakes, so the block accepts one operation per cycle and holds results under back-pressure.

## Interface
- No parameters; width fixed at 32 bits, 4 stages of 8 bits.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  A, B, Bin valid
- in_ready  out  1  block can accept this cycle
- A  in  32  minuend
- B  in  32  subtrahend
- Bin  in  1  borrow in
- out_valid  out  1  D and flags valid
- out_ready  in  1  consumer accepts this cycle
- D  out  32  difference A − B − Bin mod 2^32
- Bout  out  1  unsigned borrow out: 1 iff A < B + Bin
- overFlow  out  1  signed overflow
- zero  out  1  D == 0

## Operation
- Arithmetic: D = A + ~B + ~Bin, with the carry chain seeded by c0 = !Bin.
- Stage k (k = 0..3) computes bits [8k+7:8k] as follows:
  - Gi = A[i] & ~B[i]; Pi = A[i] ^ ~B[i].
  - Carry-lookahead across the 8 bits, seeded with the carry out of stage k−1 (c0 for stage 0).
  - The stage registers the result byte, its carry out, all not-yet-processed operand bytes, and the finished result bytes.
- Final stage outputs:
  - Bout = !c32.
  - overFlow = (A[31] != B[31]) && (D[31] != A[31]), using the original A[31] and B[31] carried down the pipe.
  - zero = (D == 0).
- Each stage has a valid bit v1..v4. Outputs are driven directly from stage-4 registers.
- Global advance: adv = !v4 | out_ready; in_ready = adv.
  - On adv, every stage loads from its predecessor, and v1 loads in_valid.
  - When adv = 0, every stage holds.
- Bubbles are not squeezed out. A stall freezes the whole pipe, including empty stages.
- Ordering is strictly FIFO. No operation is dropped or duplicated.
- Reset (asynchronous assert, any time, including mid-stream):
  - v1..v4 = 0; all data registers = 0.
  - Outputs: out_valid 0, D 0, Bout 0, overFlow 0, zero 0.
  - in_ready is 1 in the first cycle after deassertion.
  - In-flight operations are discarded.
- In-flight state: state is per-operation, so stages may hold operations with differing Bin values at the same time.

## Timing
- Input transfer: in_valid & in_ready at a rising edge. That edge loads stage 1.
- Latency with no stalls:
  - An operation accepted at edge t reaches stage 4 at edge t+3.
  - out_valid = 1 from t+3 until a transfer (out_valid & out_ready).
- Throughput: 1 op/cycle while out_ready is held at 1.
- Back-pressure: while out_valid & !out_ready, the following are held stable: D, Bout, overFlow, zero, out_valid, and all stage contents. in_ready = 0 during this time.
- Simultaneous output transfer and input accept in the same cycle is legal: the pipe shifts and loses nothing.
- in_ready is combinational from out_ready. out_valid and data are registered only.
- A, B and Bin are sampled only on the accepting edge and need not be held afterwards.

## Test plan
- **Basic subtract, latency:** reset, out_ready = 1; A = 5, B = 3, Bin = 0 accepted at edge t.
  - Required: D = 0x00000002, Bout 0, overFlow 0, zero 0.
  - out_valid rises exactly at t+3.
- **Unsigned borrow:** A = 0, B = 1, Bin = 0.
  - Required: D = 0xFFFFFFFF, Bout 1, overFlow 0.
- **Signed overflow and cross-byte carries:**
  - A = 0x80000000, B = 1 → D = 0x7FFFFFFF, overFlow 1, Bout 0.
  - A = 0x7FFFFFFF, B = 0xFFFFFFFF → D = 0x80000000, overFlow 1, Bout 1.
  - A = 0x00000100, B = 0x00000001 → D = 0x000000FF; the borrow ripples across the stage boundary.
- **Borrow-in and zero:**
  - A = 10, B = 10, Bin = 1 → D = 0xFFFFFFFF, Bout 1, zero 0.
  - A = 10, B = 9, Bin = 1 → D = 0, zero 1, Bout 0.
- **Back-pressure stream:** 16 random operations with back-to-back in_valid, out_ready driven from a pseudo-random pattern with runs of 0 lasting up to 5 cycles.
  - Results match the model in order, with none lost or duplicated.
  - Outputs are stable while stalled.
  - in_ready == !out_valid | out_ready on every cycle.
- **Reset mid-operation:** with 4 operations in flight, pulse rst_n low between clock edges.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - No stale result appears after release.
  - The next accepted operation returns the correct result at t+3.
